// File: rtl/trace_wb_slave.sv
// SDRAM command-bus trace buffer behind a Wishbone slave port.
// Non-NOP commands are stored as {cmd, dqs, cycle delta, dq} words and drained through DATA.
module trace_wb_slave #(
  parameter int unsigned depth_log2  = 9,
  parameter int unsigned delta_width = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  input  logic [15:0] sdram_dq,
  input  logic [1:0]  sdram_dqs,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic        enable_capture,
  input  logic        end_capture,
  output logic        irq
);

  localparam int unsigned Depth = 2 ** depth_log2;
  localparam int unsigned CntW  = depth_log2 + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   arm_q, arm_d, stop_q, stop_d, ovf_q, ovf_d;
  logic                   end_pend_q, end_pend_d;
  logic [delta_width-1:0] delta_q, delta_d;
  logic [depth_log2-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   ack_q, ack_d, pend_q, pend_d;
  logic                   data_ack_q, data_ack_d, data_hit_q, data_hit_d;
  logic [31:0]            dat_q, dat_d;
  logic [15:0]            dq_q;
  logic [1:0]             dqs_q;
  logic [3:0]             cmd_q;
  logic [31:0]            ram [Depth];
  logic [31:0]            rd_data_q;

  logic        req, ctrl_wr, clear, pop, push, qualify, full, empty;
  logic [31:0] status_word, push_word;
  logic        unused_bits;

  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:3]};

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign req     = wb_cyc_i & wb_stb_i & ~ack_q & ~pend_q;
  assign ctrl_wr = req & wb_we_i & (wb_adr_i[3:2] == 2'd0) & wb_sel_i[0];
  assign clear   = ctrl_wr & wb_dat_i[1];
  // DATA pops in the RAM-read cycle, only if the master is still requesting.
  assign pop     = pend_q & wb_cyc_i & wb_stb_i & ~empty;
  assign qualify = (state_q == StCapture) & ~cmd_q[3] & (cmd_q[2:0] != 3'b111);
  // A full FIFO still accepts a sample when a pop frees a slot in the same cycle.
  assign push    = qualify & (~full | pop) & ~clear;

  assign push_word   = {cmd_q, dqs_q, delta_q, dq_q};
  assign status_word = {16'(count_q), 11'd0, state_q, ovf_q, full, state_q == StCapture};

  assign wb_ack_o = ack_q;
  assign wb_dat_o = data_ack_q ? (data_hit_q ? rd_data_q : 32'd0) : dat_q;
  assign irq      = (state_q == StDone) & ~empty;

  always_comb begin
    state_d    = state_q;
    arm_d      = arm_q;
    stop_d     = stop_q;
    ovf_d      = ovf_q;
    end_pend_d = end_pend_q;
    delta_d    = '0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);
    ack_d      = 1'b0;
    pend_d     = 1'b0;
    data_ack_d = 1'b0;
    data_hit_d = pop;
    dat_d      = '0;

    if (req) begin
      unique case (wb_adr_i[3:2])
        2'd0: begin
          ack_d = 1'b1;
          dat_d = {29'd0, stop_q, 1'b0, arm_q};
        end
        2'd1: begin
          ack_d = 1'b1;
          dat_d = status_word;
        end
        2'd2: pend_d = 1'b1;
        2'd3: ack_d  = 1'b1;
      endcase
    end
    if (pend_q && wb_cyc_i && wb_stb_i) begin
      ack_d      = 1'b1;
      data_ack_d = 1'b1;
    end

    if (state_q == StCapture) begin
      if (push) begin
        delta_d = '0;
      end else begin
        delta_d = (delta_q == {delta_width{1'b1}}) ? delta_q : delta_q + 1'b1;
      end
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (qualify && full && !pop && !stop_q) ovf_d = 1'b1;

    unique case (state_q)
      StArmed: begin
        if (enable_capture) begin
          state_d    = StCapture;
          // Both pulses together still grant one capture cycle before stopping.
          end_pend_d = end_capture;
        end
      end
      StCapture: begin
        if (end_capture || end_pend_q || (stop_q && full)) state_d = StDone;
        end_pend_d = 1'b0;
      end
      default: ;
    endcase

    if (ctrl_wr) begin
      arm_d  = wb_dat_i[0];
      stop_d = wb_dat_i[2];
      if (!wb_dat_i[0]) begin
        state_d    = StIdle;
        end_pend_d = 1'b0;
      end else if (state_q == StIdle) begin
        state_d = StArmed;
      end
    end

    if (clear) begin
      state_d    = StIdle;
      arm_d      = 1'b0;
      ovf_d      = 1'b0;
      end_pend_d = 1'b0;
      delta_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      arm_q      <= 1'b0;
      stop_q     <= 1'b0;
      ovf_q      <= 1'b0;
      end_pend_q <= 1'b0;
      delta_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      pend_q     <= 1'b0;
      data_ack_q <= 1'b0;
      data_hit_q <= 1'b0;
      dat_q      <= '0;
      dq_q       <= '0;
      dqs_q      <= '0;
      cmd_q      <= 4'hf;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      stop_q     <= stop_d;
      ovf_q      <= ovf_d;
      end_pend_q <= end_pend_d;
      delta_q    <= delta_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ack_q      <= ack_d;
      pend_q     <= pend_d;
      data_ack_q <= data_ack_d;
      data_hit_q <= data_hit_d;
      dat_q      <= dat_d;
      dq_q       <= sdram_dq;
      dqs_q      <= sdram_dqs;
      cmd_q      <= {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    end
  end

  // Read-first RAM: a push and pop on the same slot (full FIFO) returns the old entry.
  always_ff @(posedge sys_clk) begin
    if (push) ram[wr_ptr_q] <= push_word;
    rd_data_q <= ram[rd_ptr_q];
  end

endmodule

// File: tb/tb_trace_wb_slave.sv
// Bench for trace_wb_slave: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_trace_wb_slave;

  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat = '0, wb_dat_o;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0, wb_ack_o;
  logic [15:0] sdram_dq = '0;
  logic [1:0]  sdram_dqs = '0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic        enable_capture = 1'b0, end_capture = 1'b0, irq;
  logic        rand_on = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  trace_wb_slave #(.depth_log2(4), .delta_width(10)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel),
    .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_ack_o(wb_ack_o),
    .sdram_dq(sdram_dq), .sdram_dqs(sdram_dqs),
    .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
    .enable_capture(enable_capture), .end_capture(end_capture), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: state as 0..3, FIFO as a queue, delta as a saturating int.
  int          m_state, m_delta;
  logic        m_arm, m_stop, m_ovf, m_endp, m_ack, m_pend;
  logic [31:0] m_dat;
  logic [31:0] mq[$];
  logic [3:0]  s_cmd;
  logic [1:0]  s_dqs;
  logic [15:0] s_dq;

  function automatic void model_reset();
    m_state = 0; m_delta = 0; m_arm = 0; m_stop = 0; m_ovf = 0; m_endp = 0;
    m_ack = 0; m_pend = 0; m_dat = 0; mq.delete();
    s_cmd = 4'hf; s_dqs = 0; s_dq = 0;
  endfunction

  function automatic void model_step();
    logic req, wctrl, pop_now, qual, full_old, pushed;
    logic [1:0] a;
    int st;
    if (!rst_n) begin
      model_reset();
      return;
    end
    st       = m_state;
    a        = wb_adr[3:2];
    full_old = (mq.size() == Depth);
    req      = wb_cyc && wb_stb && !m_ack && !m_pend;
    pop_now  = m_pend && wb_cyc && wb_stb && (mq.size() > 0);
    wctrl    = req && wb_we && a == 2'd0 && wb_sel[0];

    m_dat = 0;
    if (req && a != 2'd2) begin
      m_ack = 1;
      if (a == 2'd0) m_dat = {29'd0, m_stop, 1'b0, m_arm};
      else if (a == 2'd1)
        m_dat = (32'(mq.size()) << 16) | (32'(st) << 3) | {29'd0, m_ovf, full_old, st == 2};
    end else if (m_pend && wb_cyc && wb_stb) begin
      m_ack = 1;
      m_dat = pop_now ? mq[0] : 32'd0;
    end else begin
      m_ack = 0;
    end
    m_pend = req && a == 2'd2;

    if (wctrl && wb_dat[1]) begin
      mq.delete(); m_ovf = 0; m_state = 0; m_arm = 0; m_stop = wb_dat[2];
      m_delta = 0; m_endp = 0;
    end else begin
      pushed = 0;
      if (pop_now) void'(mq.pop_front());
      qual = (st == 2) && !s_cmd[3] && s_cmd[2:0] != 3'b111;
      if (qual) begin
        if (!full_old || pop_now) begin
          mq.push_back({s_cmd, s_dqs, 10'(m_delta), s_dq});
          pushed = 1;
        end else if (!m_stop) begin
          m_ovf = 1;
        end
      end
      if (st != 2 || pushed) m_delta = 0;
      else if (m_delta < 1023) m_delta++;
      if (wctrl && !wb_dat[0]) begin
        m_state = 0; m_endp = 0;
      end else begin
        case (st)
          0: if (wctrl) m_state = 1;
          1: if (enable_capture) begin m_state = 2; m_endp = end_capture; end
          2: begin
            if (end_capture || m_endp || (m_stop && full_old)) m_state = 3;
            m_endp = 0;
          end
          default: ;
        endcase
      end
      if (wctrl) begin m_arm = wb_dat[0]; m_stop = wb_dat[2]; end
    end
    s_cmd = {cs_n, ras_n, cas_n, we_n};
    s_dqs = sdram_dqs;
    s_dq  = sdram_dq;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      if (rst_n) begin
        check("ack", 32'(wb_ack_o), 32'(m_ack));
        check("irq", 32'(irq), 32'(m_state == 3 && mq.size() > 0));
        if (m_ack) check("rdata", wb_dat_o, m_dat);
      end
    end
  end

  always @(negedge clk) begin
    if (rand_on) begin
      sdram_dq  = 16'($urandom);
      sdram_dqs = 2'($urandom);
      cs_n      = ($urandom_range(0, 1) == 0);
      {ras_n, cas_n, we_n} = 3'($urandom);
      enable_capture = ($urandom_range(0, 19) == 0);
      end_capture    = ($urandom_range(0, 39) == 0);
    end
  end

  task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rdat);
    int n;
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = {28'd0, a, 2'b00}; wb_dat = d; wb_sel = sel;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 8);
    check("ack_wait", 32'(wb_ack_o), 32'd1);
    rdat = wb_dat_o;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
  endtask

  task automatic wb_abandon();
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h8;
    @(negedge clk);
    wb_cyc = 0; wb_stb = 0;
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic [3:0] c, input logic [15:0] d, input logic [1:0] s);
    {cs_n, ras_n, cas_n, we_n} = c;
    sdram_dq = d;
    sdram_dqs = s;
  endtask

  task automatic fill20(input logic [31:0] ctrl);
    logic [31:0] rd;
    wb_xfer(1, 2'd0, ctrl, 4'hf, rd);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      enable_capture = (i == 0);
      set_cmd(4'b0100, 16'(i), 2'b10);
    end
    @(negedge clk);
    set_cmd(4'hf, 16'd0, 2'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    #20000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int op;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Reset mid-DATA read
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h8; wb_sel = 4'hf;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rst_pre_ack", 32'(wb_ack_o), 32'd1);
    rst_n = 0;
    #1;
    check("rst_ack_drop", 32'(wb_ack_o), 32'd0);
    wb_cyc = 0; wb_stb = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    wb_xfer(0, 2'd1, 0, 4'hf, rd);
    check("rst_status", rd, 32'h0000_0000);

    // Basic capture: three ACTIVE commands five cycles apart
    wb_xfer(1, 2'd0, 32'd1, 4'hf, rd);
    @(negedge clk); enable_capture = 1; set_cmd(4'b0011, 16'h1111, 2'b01);
    @(negedge clk); enable_capture = 0; set_cmd(4'hf, 16'd0, 2'd0);
    repeat (4) @(negedge clk);
    set_cmd(4'b0011, 16'h2222, 2'b01);
    @(negedge clk); set_cmd(4'hf, 16'd0, 2'd0);
    repeat (4) @(negedge clk);
    set_cmd(4'b0011, 16'h3333, 2'b01);
    @(negedge clk); set_cmd(4'hf, 16'd0, 2'd0);
    @(negedge clk); end_capture = 1;
    @(negedge clk); end_capture = 0;
    wb_xfer(0, 2'd1, 0, 4'hf, rd);
    check("basic_status", rd, 32'h0003_0018);
    check("basic_irq", 32'(irq), 32'd1);
    wb_xfer(0, 2'd2, 0, 4'hf, rd); check("basic_w0", rd, 32'h3400_1111);
    wb_xfer(0, 2'd2, 0, 4'hf, rd); check("basic_w1", rd, 32'h3404_2222);
    wb_xfer(0, 2'd2, 0, 4'hf, rd); check("basic_w2", rd, 32'h3404_3333);
    wb_xfer(0, 2'd2, 0, 4'hf, rd); check("basic_empty", rd, 32'h0000_0000);
    wb_xfer(1, 2'd0, 32'd0, 4'hf, rd);

    // NOP filter and delta saturation
    wb_xfer(1, 2'd0, 32'd1, 4'hf, rd);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      enable_capture = (i == 0);
      if ($urandom_range(0, 1) == 0) set_cmd({1'b1, 3'($urandom)}, 16'($urandom), 2'd3);
      else set_cmd(4'b0111, 16'($urandom), 2'd0);
    end
    @(negedge clk); set_cmd(4'b0101, 16'habcd, 2'b11);
    @(negedge clk); set_cmd(4'hf, 16'd0, 2'd0);
    @(negedge clk); end_capture = 1;
    @(negedge clk); end_capture = 0;
    wb_xfer(0, 2'd1, 0, 4'hf, rd);
    check("nop_status", rd, 32'h0001_0018);
    wb_xfer(0, 2'd2, 0, 4'hf, rd);
    check("nop_word", rd, 32'h5fff_abcd);
    wb_xfer(1, 2'd0, 32'd0, 4'hf, rd);

    // Full with stop_on_full=1
    fill20(32'd5);
    wb_xfer(0, 2'd1, 0, 4'hf, rd);
    check("full_stop_status", rd, 32'h0010_001a);
    check("full_stop_irq", 32'(irq), 32'd1);
    wb_xfer(1, 2'd0, 32'd2, 4'hf, rd);

    // Full with stop_on_full=0
    fill20(32'd1);
    wb_xfer(0, 2'd1, 0, 4'hf, rd);
    check("full_ovf_status", rd, 32'h0010_0017);

    // Pop while a command is captured at full, then clear
    set_cmd(4'b0100, 16'hbeef, 2'b10);
    wb_xfer(0, 2'd2, 0, 4'hf, rd);
    check("conc_word", rd, 32'h4800_0000);
    set_cmd(4'hf, 16'd0, 2'd0);
    wb_xfer(0, 2'd1, 0, 4'hf, rd);
    check("conc_status", rd, 32'h0010_0017);
    wb_xfer(1, 2'd0, 32'd2, 4'hf, rd);
    wb_xfer(0, 2'd1, 0, 4'hf, rd);
    check("clear_status", rd, 32'h0000_0000);
    check("clear_irq", 32'(irq), 32'd0);

    // Randomized traffic
    rand_on = 1;
    for (int i = 0; i < 600; i++) begin
      op = $urandom_range(0, 15);
      case (op)
        0, 1: wb_xfer(1, 2'd0, {29'd0, 1'($urandom), 2'b01}, 4'hf, rd);
        2: wb_xfer(1, 2'd0, 32'd0, 4'hf, rd);
        3: begin
          if ($urandom_range(0, 3) == 0) wb_xfer(1, 2'd0, 32'd2, 4'hf, rd);
          else wb_xfer(0, 2'd1, 0, 4'hf, rd);
        end
        4, 5, 6, 7, 8: wb_xfer(0, 2'd2, 0, 4'hf, rd);
        9: wb_xfer(0, 2'd1, 0, 4'hf, rd);
        10: wb_xfer(0, 2'd0, 0, 4'hf, rd);
        11: wb_xfer(1'($urandom), 2'd3, $urandom, 4'hf, rd);
        12: wb_xfer(1, 2'($urandom_range(1, 2)), $urandom, 4'hf, rd);
        13: wb_xfer(1, 2'd0, $urandom, 4'he, rd);
        14: wb_abandon();
        default: repeat ($urandom_range(1, 6)) @(negedge clk);
      endcase
    end
    rand_on = 0;
    @(negedge clk);
    enable_capture = 0; end_capture = 0;
    set_cmd(4'hf, 16'd0, 2'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
